// File: rtl/stopwatch_ctrl_if.sv
// Control/status bundle between the stopwatch run-control FSM and its neighbours.
// Button/switch levels flow into the controller; pulses and status flow out.
interface stopwatch_ctrl_if;
    logic       pause_btn;
    logic       reset_btn;
    logic       adj_sw;
    logic       sel_sw;
    logic       cnt_tick;
    logic       clr;
    logic       adj_min;
    logic       adj_sec;
    logic       blink;
    logic       running;
    logic [1:0] state_o;

    modport master (
        output pause_btn, reset_btn, adj_sw, sel_sw,
        input  cnt_tick, clr, adj_min, adj_sec, blink, running, state_o
    );

    modport slave (
        input  pause_btn, reset_btn, adj_sw, sel_sw,
        output cnt_tick, clr, adj_min, adj_sec, blink, running, state_o
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control FSM: button edge detection, state sequencing, and the
// tick / adjust / blink prescalers. Every output comes straight from a register.
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int ADJ_DIV   = 50_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  sw
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        ADJUST = 2'b11
    } state_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ADJ_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] AMAX = AW'(ADJ_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

    state_t          state_reg, state_next;
    logic [TW-1:0]   tcnt_reg, tcnt_next;
    logic [AW-1:0]   acnt_reg, acnt_next;
    logic [BW-1:0]   bcnt_reg, bcnt_next;
    logic            pause_q_reg, reset_q_reg;
    logic            tick_reg, tick_next;
    logic            clr_reg, clr_next;
    logic            adj_min_reg, adj_min_next;
    logic            adj_sec_reg, adj_sec_next;
    logic            blink_reg, blink_next;
    logic            running_reg, running_next;
    logic            rise_pause, rise_reset, stay_adj;

    assign rise_pause = sw.pause_btn & ~pause_q_reg;
    assign rise_reset = sw.reset_btn & ~reset_q_reg;

    always_comb begin
        state_next   = state_reg;
        tcnt_next    = tcnt_reg;
        acnt_next    = '0;
        bcnt_next    = '0;
        tick_next    = 1'b0;
        clr_next     = rise_reset;
        adj_min_next = 1'b0;
        adj_sec_next = 1'b0;
        blink_next   = 1'b0;

        if (rise_reset) begin
            state_next = IDLE;
        end else if (sw.adj_sw && state_reg != ADJUST) begin
            state_next = ADJUST;
        end else if (!sw.adj_sw && state_reg == ADJUST) begin
            state_next = PAUSED;
        end else if (rise_pause) begin
            case (state_reg)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSED;
                PAUSED:  state_next = RUN;
                default: state_next = state_reg;
            endcase
        end
        running_next = (state_next == RUN);

        // tcnt keeps its phase outside RUN so a pause does not lose sub-second time
        if (rise_reset) begin
            tcnt_next = '0;
        end else if (state_reg == RUN) begin
            if (tcnt_reg == TMAX) begin
                tcnt_next = '0;
                tick_next = 1'b1;
            end else begin
                tcnt_next = tcnt_reg + 1'b1;
            end
        end

        if (state_reg == ADJUST && acnt_reg == AMAX && !rise_reset) begin
            adj_sec_next = sw.sel_sw;
            adj_min_next = ~sw.sel_sw;
        end

        // Adjust and blink prescalers restart from zero on every ADJUST entry
        stay_adj = (state_reg == ADJUST) && (state_next == ADJUST);
        if (stay_adj) begin
            acnt_next  = (acnt_reg == AMAX) ? '0 : acnt_reg + 1'b1;
            bcnt_next  = (bcnt_reg == BMAX) ? '0 : bcnt_reg + 1'b1;
            blink_next = (bcnt_reg == BMAX) ? ~blink_reg : blink_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            tcnt_reg    <= '0;
            acnt_reg    <= '0;
            bcnt_reg    <= '0;
            pause_q_reg <= 1'b1;
            reset_q_reg <= 1'b1;
            tick_reg    <= 1'b0;
            clr_reg     <= 1'b0;
            adj_min_reg <= 1'b0;
            adj_sec_reg <= 1'b0;
            blink_reg   <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tcnt_reg    <= tcnt_next;
            acnt_reg    <= acnt_next;
            bcnt_reg    <= bcnt_next;
            pause_q_reg <= sw.pause_btn;
            reset_q_reg <= sw.reset_btn;
            tick_reg    <= tick_next;
            clr_reg     <= clr_next;
            adj_min_reg <= adj_min_next;
            adj_sec_reg <= adj_sec_next;
            blink_reg   <= blink_next;
            running_reg <= running_next;
        end
    end

    assign sw.cnt_tick = tick_reg;
    assign sw.clr      = clr_reg;
    assign sw.adj_min  = adj_min_reg;
    assign sw.adj_sec  = adj_sec_reg;
    assign sw.blink    = blink_reg;
    assign sw.running  = running_reg;
    assign sw.state_o  = state_reg;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with small dividers (4/3/2); expected
// values are hand-derived cycle counts from RUN/ADJUST entry.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic seen_tick;

    stopwatch_ctrl_if swif ();

    stopwatch_ctrl #(
        .TICK_DIV  (4),
        .ADJ_DIV   (3),
        .BLINK_DIV (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (swif.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Steps n cycles; cnt_tick must be low on all but the last, high on the last.
    task automatic expect_tick_at(input int n, input string tag);
        for (int k = 1; k <= n; k++) begin
            step();
            check(tag, 32'(swif.cnt_tick), (k == n) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        swif.pause_btn = 1'b1;
        swif.reset_btn = 1'b0;
        swif.adj_sw    = 1'b0;
        swif.sel_sw    = 1'b0;

        // 1) reset with pause held: no edge, stay IDLE
        step();
        step();
        rst = 1'b0;
        $display("reset: state=%0d", swif.state_o);
        check("rst_state",   32'(swif.state_o),  32'd0);
        check("rst_tick",    32'(swif.cnt_tick), 32'd0);
        check("rst_clr",     32'(swif.clr),      32'd0);
        check("rst_running", 32'(swif.running),  32'd0);
        check("rst_blink",   32'(swif.blink),    32'd0);
        check("rst_adj",     32'({swif.adj_min, swif.adj_sec}), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("held_state", 32'(swif.state_o),  32'd0);
            check("held_tick",  32'(swif.cnt_tick), 32'd0);
        end

        // 2) pause press: IDLE -> RUN, tick every 4 cycles
        swif.pause_btn = 1'b0;
        step();
        swif.pause_btn = 1'b1;
        step();
        $display("start: state=%0d running=%0d", swif.state_o, swif.running);
        check("start_state",   32'(swif.state_o), 32'd1);
        check("start_running", 32'(swif.running), 32'd1);
        swif.pause_btn = 1'b0;
        expect_tick_at(4, "tick_first");
        expect_tick_at(4, "tick_second");

        // 3) pause with tcnt reaching 2, hold 10 cycles, resume -> tick after 2
        step();
        swif.pause_btn = 1'b1;
        step();
        $display("pause: state=%0d", swif.state_o);
        check("pause_state",   32'(swif.state_o), 32'd2);
        check("pause_running", 32'(swif.running), 32'd0);
        swif.pause_btn = 1'b0;
        seen_tick = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            seen_tick = seen_tick | swif.cnt_tick;
        end
        check("pause_no_tick", 32'(seen_tick), 32'd0);
        swif.pause_btn = 1'b1;
        step();
        $display("resume: state=%0d", swif.state_o);
        check("resume_state", 32'(swif.state_o), 32'd1);
        swif.pause_btn = 1'b0;
        expect_tick_at(2, "resume_phase");

        // 4) simultaneous reset and pause edges in RUN
        step();
        swif.pause_btn = 1'b1;
        swif.reset_btn = 1'b1;
        step();
        $display("clear: state=%0d clr=%0d", swif.state_o, swif.clr);
        check("clr_state",   32'(swif.state_o), 32'd0);
        check("clr_pulse",   32'(swif.clr),     32'd1);
        check("clr_running", 32'(swif.running), 32'd0);
        step();
        check("clr_once",   32'(swif.clr),     32'd0);
        check("clr_stays",  32'(swif.state_o), 32'd0);
        swif.pause_btn = 1'b0;
        swif.reset_btn = 1'b0;
        step();
        swif.pause_btn = 1'b1;
        step();
        check("restart_state", 32'(swif.state_o), 32'd1);
        swif.pause_btn = 1'b0;
        expect_tick_at(4, "tcnt_cleared");

        // 5) ADJUST from RUN: seconds then minutes, blink cadence
        swif.adj_sw = 1'b1;
        swif.sel_sw = 1'b1;
        step();
        $display("adjust: state=%0d blink=%0d", swif.state_o, swif.blink);
        check("adj_state",   32'(swif.state_o), 32'd3);
        check("adj_running", 32'(swif.running), 32'd0);
        check("adj_blink0",  32'(swif.blink),   32'd0);
        for (int k = 1; k <= 9; k++) begin
            if (k == 7) swif.sel_sw = 1'b0;
            step();
            check("adj_sec",   32'(swif.adj_sec),  (k <= 6 && k % 3 == 0) ? 32'd1 : 32'd0);
            check("adj_min",   32'(swif.adj_min),  (k == 9) ? 32'd1 : 32'd0);
            check("adj_notick", 32'(swif.cnt_tick), 32'd0);
            check("adj_blink", 32'(swif.blink),    32'((k / 2) % 2));
        end
        swif.adj_sw = 1'b0;
        step();
        $display("adjust exit: state=%0d blink=%0d", swif.state_o, swif.blink);
        check("adjx_state", 32'(swif.state_o), 32'd2);
        check("adjx_blink", 32'(swif.blink),   32'd0);
        check("adjx_min",   32'(swif.adj_min), 32'd0);

        // 6) pause ignored in ADJUST; reset forces IDLE then back to ADJUST
        swif.adj_sw = 1'b1;
        step();
        check("adj2_state", 32'(swif.state_o), 32'd3);
        swif.pause_btn = 1'b1;
        step();
        check("adj2_ign1", 32'(swif.state_o), 32'd3);
        swif.pause_btn = 1'b0;
        step();
        check("adj2_ign2", 32'(swif.state_o), 32'd3);
        swif.pause_btn = 1'b1;
        step();
        check("adj2_ign3", 32'(swif.state_o), 32'd3);
        check("adj2_min",  32'(swif.adj_min), 32'd1);
        swif.pause_btn = 1'b0;
        swif.reset_btn = 1'b1;
        step();
        $display("adjust clear: state=%0d clr=%0d", swif.state_o, swif.clr);
        check("adjc_state", 32'(swif.state_o), 32'd0);
        check("adjc_clr",   32'(swif.clr),     32'd1);
        check("adjc_adj",   32'({swif.adj_min, swif.adj_sec}), 32'd0);
        check("adjc_blink", 32'(swif.blink),   32'd0);
        swif.reset_btn = 1'b0;
        step();
        $display("adjust reenter: state=%0d", swif.state_o);
        check("adjr_state", 32'(swif.state_o), 32'd3);
        check("adjr_clr",   32'(swif.clr),     32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
